// File: rtl/id_exe_pipe_reg.sv
// ID/EX pipeline register of the 5-stage ARM core.
//
// Captures the decoded control word and operands from the ID stage and presents
// them to EX one cycle later. Every output is a flop.
//
// Ports:
//   clk, rst_n       core clock, synchronous active-low reset
//   flush            replace the instruction entering EX with a bubble
//   freeze           hold all registered state; counts stall cycles
//   cond_pass        0 = the ID instruction failed its condition and retires as a no-op
//   *_in / *_out     control word and operands, registered copies
//   valid_out        EX holds a real (non-bubble) instruction
//   stall_cnt        saturating count of frozen cycles since reset
module id_exe_pipe_reg #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   freeze,
    input  logic                   cond_pass,
    input  logic [3:0]             exec_cmd_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic                   wb_en_in,
    input  logic                   status_w_en_in,
    input  logic                   branch_taken_in,
    input  logic                   imm_in,
    input  logic [WORD_W-1:0]      pc_in,
    input  logic [WORD_W-1:0]      val_rn_in,
    input  logic [WORD_W-1:0]      val_rm_in,
    input  logic [11:0]            shift_operand_in,
    input  logic [23:0]            signed_imm24_in,
    input  logic [REG_ADDR_W-1:0]  dest_in,
    input  logic [REG_ADDR_W-1:0]  src1_in,
    input  logic [REG_ADDR_W-1:0]  src2_in,
    input  logic [3:0]             status_in,
    output logic [3:0]             exec_cmd_out,
    output logic                   mem_r_en_out,
    output logic                   mem_w_en_out,
    output logic                   wb_en_out,
    output logic                   status_w_en_out,
    output logic                   branch_taken_out,
    output logic                   imm_out,
    output logic [WORD_W-1:0]      pc_out,
    output logic [WORD_W-1:0]      val_rn_out,
    output logic [WORD_W-1:0]      val_rm_out,
    output logic [11:0]            shift_operand_out,
    output logic [23:0]            signed_imm24_out,
    output logic [REG_ADDR_W-1:0]  dest_out,
    output logic [REG_ADDR_W-1:0]  src1_out,
    output logic [REG_ADDR_W-1:0]  src2_out,
    output logic [3:0]             status_out,
    output logic                   valid_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            // Reset and flush both leave a bubble; only reset clears the counter.
            exec_cmd_out      <= '0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            status_w_en_out   <= 1'b0;
            branch_taken_out  <= 1'b0;
            imm_out           <= 1'b0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            signed_imm24_out  <= '0;
            dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            status_out        <= '0;
            valid_out         <= 1'b0;
            if (!rst_n) begin
                stall_cnt <= '0;
            end
        end else if (freeze) begin
            // Pipeline contents hold; counter saturates instead of wrapping.
            if (stall_cnt != {STALL_CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end else begin
            exec_cmd_out      <= exec_cmd_in;
            imm_out           <= imm_in;
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm24_out  <= signed_imm24_in;
            dest_out          <= dest_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            status_out        <= status_in;
            // A condition-failed instruction still occupies EX but has no side effects.
            mem_r_en_out      <= mem_r_en_in     & cond_pass;
            mem_w_en_out      <= mem_w_en_in     & cond_pass;
            wb_en_out         <= wb_en_in        & cond_pass;
            status_w_en_out   <= status_w_en_in  & cond_pass;
            branch_taken_out  <= branch_taken_in & cond_pass;
            valid_out         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
module tb_id_exe_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, flush, freeze, cond_pass;
    logic [3:0]  exec_cmd_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm24_in;
    logic [3:0]  dest_in, src1_in, src2_in, status_in;

    logic [3:0]  exec_cmd_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, status_w_en_out, branch_taken_out;
    logic        imm_out, valid_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm24_out;
    logic [3:0]  dest_out, src1_out, src2_out, status_out;
    logic [15:0] stall_cnt;

    // Second instance with a narrow counter for the saturation check.
    logic [3:0]  s_exec_cmd_out;
    logic        s_mem_r_en_out, s_mem_w_en_out, s_wb_en_out, s_status_w_en_out;
    logic        s_branch_taken_out, s_imm_out, s_valid_out;
    logic [31:0] s_pc_out, s_val_rn_out, s_val_rm_out;
    logic [11:0] s_shift_operand_out;
    logic [23:0] s_signed_imm24_out;
    logic [3:0]  s_dest_out, s_src1_out, s_src2_out, s_status_out;
    logic [3:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_exe_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze), .cond_pass(cond_pass),
        .exec_cmd_in(exec_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .status_w_en_in(status_w_en_in),
        .branch_taken_in(branch_taken_in), .imm_in(imm_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
        .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .src1_in(src1_in),
        .src2_in(src2_in), .status_in(status_in),
        .exec_cmd_out(exec_cmd_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
        .status_w_en_out(status_w_en_out), .branch_taken_out(branch_taken_out),
        .imm_out(imm_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
        .signed_imm24_out(signed_imm24_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .status_out(status_out), .valid_out(valid_out),
        .stall_cnt(stall_cnt)
    );

    id_exe_pipe_reg #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze), .cond_pass(cond_pass),
        .exec_cmd_in(exec_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .status_w_en_in(status_w_en_in),
        .branch_taken_in(branch_taken_in), .imm_in(imm_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
        .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .src1_in(src1_in),
        .src2_in(src2_in), .status_in(status_in),
        .exec_cmd_out(s_exec_cmd_out), .mem_r_en_out(s_mem_r_en_out),
        .mem_w_en_out(s_mem_w_en_out), .wb_en_out(s_wb_en_out),
        .status_w_en_out(s_status_w_en_out), .branch_taken_out(s_branch_taken_out),
        .imm_out(s_imm_out), .pc_out(s_pc_out), .val_rn_out(s_val_rn_out),
        .val_rm_out(s_val_rm_out), .shift_operand_out(s_shift_operand_out),
        .signed_imm24_out(s_signed_imm24_out), .dest_out(s_dest_out), .src1_out(s_src1_out),
        .src2_out(s_src2_out), .status_out(s_status_out), .valid_out(s_valid_out),
        .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic v);
        cond_pass        = v;
        exec_cmd_in      = {4{v}};
        mem_r_en_in      = v;
        mem_w_en_in      = v;
        wb_en_in         = v;
        status_w_en_in   = v;
        branch_taken_in  = v;
        imm_in           = v;
        pc_in            = {32{v}};
        val_rn_in        = {32{v}};
        val_rm_in        = {32{v}};
        shift_operand_in = {12{v}};
        signed_imm24_in  = {24{v}};
        dest_in          = {4{v}};
        src1_in          = {4{v}};
        src2_in          = {4{v}};
        status_in        = {4{v}};
    endtask

    initial begin
        flush  = 1'b0;
        freeze = 1'b0;
        rst_n  = 1'b0;
        set_inputs(1'b1);
        step();
        step();
        check("rst_exec_cmd", exec_cmd_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_wb_en", wb_en_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // First load after release: all-ones inputs appear one cycle later.
        rst_n = 1'b1;
        step();
        check("first_pc", pc_out, 64'hFFFF_FFFF);
        check("first_imm24", signed_imm24_out, 64'hFF_FFFF);
        check("first_mem_r_en", mem_r_en_out, 1);
        check("first_valid", valid_out, 1);

        // ADD r3
        set_inputs(1'b0);
        cond_pass   = 1'b1;
        exec_cmd_in = 4'b0010;
        wb_en_in    = 1'b1;
        dest_in     = 4'd3;
        val_rn_in   = 32'h5;
        val_rm_in   = 32'h7;
        step();
        check("add_exec_cmd", exec_cmd_out, 4'b0010);
        check("add_wb_en", wb_en_out, 1);
        check("add_dest", dest_out, 3);
        check("add_rm", val_rm_out, 32'h7);
        check("add_mem_r_en", mem_r_en_out, 0);
        check("add_valid", valid_out, 1);

        // Freeze holds contents and counts cycles.
        val_rn_in = 32'hA;
        step();
        check("frz_load_rn", val_rn_out, 32'hA);
        freeze = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            val_rn_in = 32'hB0 + 32'(i);
            dest_in   = 4'(i + 8);
            step();
            check("frz_hold_rn", val_rn_out, 32'hA);
            check("frz_hold_dest", dest_out, 3);
            check("frz_cnt", stall_cnt, 64'(i));
        end
        freeze = 1'b0;
        step();
        check("unfrz_rn", val_rn_out, 32'hB3);
        check("unfrz_dest", dest_out, 4'd11);
        check("unfrz_cnt", stall_cnt, 3);

        // LDR under flush and freeze together: bubble, counter unchanged.
        set_inputs(1'b0);
        cond_pass   = 1'b1;
        mem_r_en_in = 1'b1;
        wb_en_in    = 1'b1;
        pc_in       = 32'h100;
        flush       = 1'b1;
        freeze      = 1'b1;
        step();
        check("flush_mem_r_en", mem_r_en_out, 0);
        check("flush_wb_en", wb_en_out, 0);
        check("flush_pc", pc_out, 0);
        check("flush_valid", valid_out, 0);
        check("flush_cnt", stall_cnt, 3);

        // STR with failed condition: operands pass, side effects squashed.
        flush  = 1'b0;
        freeze = 1'b0;
        set_inputs(1'b0);
        cond_pass       = 1'b0;
        mem_w_en_in     = 1'b1;
        status_w_en_in  = 1'b1;
        branch_taken_in = 1'b1;
        exec_cmd_in     = 4'b0100;
        val_rm_in       = 32'hDEAD;
        step();
        check("cf_mem_w_en", mem_w_en_out, 0);
        check("cf_status_w_en", status_w_en_out, 0);
        check("cf_branch", branch_taken_out, 0);
        check("cf_rm", val_rm_out, 32'hDEAD);
        check("cf_exec_cmd", exec_cmd_out, 4'b0100);
        check("cf_valid", valid_out, 1);

        // Saturation on the 4-bit counter.
        rst_n = 1'b0;
        step();
        check("sat_pre_cnt", s_stall_cnt, 0);
        rst_n  = 1'b1;
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) check("sat_reach15", s_stall_cnt, 15);
        end
        check("sat_cnt", s_stall_cnt, 15);
        check("wide_cnt20", stall_cnt, 20);
        rst_n = 1'b0;
        step();
        check("sat_rst_cnt", s_stall_cnt, 0);
        check("wide_rst_cnt", stall_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage ARM core.
- Sits directly downstream of the decode-stage control unit and register file, and feeds the execute stage (ALU, status register, branch adder).
- Captures the control word (exec_cmd, mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, imm) and operands each cycle.
- Supports flush (taken branch), freeze (hazard stall) and condition-fail squash, and keeps a saturating stall counter for performance monitoring.

Parameters:
WORD_W, 32, datapath width (pc, val_rn, val_rm)
REG_ADDR_W, 4, register address width
STALL_CNT_W, 16, width of the stall counter

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
flush  input  1  squash the instruction entering EX (branch taken in EX)
freeze  input  1  hold all registered state (hazard stall)
cond_pass  input  1  condition-code check result for the ID instruction; 0 = squash the control fields
exec_cmd_in  input  4  ALU command from the control unit
mem_r_en_in  input  1  load enable
mem_w_en_in  input  1  store enable
wb_en_in  input  1  writeback enable
status_w_en_in  input  1  S bit
branch_taken_in  input  1  branch instruction
imm_in  input  1  immediate operand select
pc_in  input  WORD_W  PC+4 of the ID instruction
val_rn_in  input  WORD_W  Rn value
val_rm_in  input  WORD_W  Rm value
shift_operand_in  input  12  shifter operand field
signed_imm24_in  input  24  branch offset
dest_in  input  REG_ADDR_W  destination register
src1_in  input  REG_ADDR_W  Rn address (forwarding)
src2_in  input  REG_ADDR_W  Rm address (forwarding)
status_in  input  4  NZCV captured at ID
*_out  output  same as matching *_in  registered copies of every *_in above
valid_out  output  1  EX holds a real (non-bubble) instruction
stall_cnt  output  STALL_CNT_W  number of frozen cycles since reset

Behaviour:
- Latency: 1 cycle. Every output is a flop; no combinational path from input to output.
- Priority, evaluated each rising edge: rst_n=0 > flush > freeze > load.
- Reset (rst_n=0 at the edge): all *_out, valid_out and stall_cnt go to 0. Reset mid-stall also clears the counter.
- Flush: all *_out are set to 0, valid_out=0. This inserts a bubble that performs no write, memory access or branch.
  - Flush wins over a simultaneous freeze.
  - stall_cnt does not increment on a flush cycle.
- Freeze (flush=0): every *_out and valid_out hold their previous value.
  - stall_cnt increments by 1 and saturates at 2^STALL_CNT_W-1; no wrap-around.
- Load (flush=0, freeze=0): all datapath fields are captured unconditionally (pc, val_rn, val_rm, shift_operand, signed_imm24, dest, src1, src2, status, imm, exec_cmd).
  - If cond_pass=1: mem_r_en, mem_w_en, wb_en, status_w_en and branch_taken are captured; valid_out=1.
  - If cond_pass=0: those five are forced to 0; valid_out=1 (the instruction retires as a no-op).
- A NOP from decode (all control bits 0) loads normally, with valid_out=1.
- mem_r_en_out and mem_w_en_out are never both 1. Decode guarantees this; the block does not check it.
- The block holds no other state. Inputs are treated as don't-care while rst_n=0.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all inputs at 1s, then release → all outputs 0, stall_cnt=0. First load after release shows the inputs one cycle later.
- Normal load: ADD (exec_cmd_in=4'b0010 ALU code, wb_en_in=1, dest_in=3, val_rn_in=32'h5, val_rm_in=32'h7, cond_pass=1) → next cycle exec_cmd_out=4'b0010, wb_en_out=1, dest_out=3, valid_out=1.
- Freeze: after a load of val_rn=32'hA, hold freeze=1 for 3 cycles while changing inputs → outputs stay at 32'hA, stall_cnt goes 0→3. Deasserting freeze captures the current inputs.
- Flush vs freeze: flush=1 and freeze=1 in the same cycle with an LDR (mem_r_en_in=1, wb_en_in=1) on the inputs → all outputs 0, valid_out=0, stall_cnt unchanged.
- Condition fail: STR with cond_pass=0 (mem_w_en_in=1, val_rm_in=32'hDEAD) → mem_w_en_out=0, val_rm_out=32'hDEAD, valid_out=1.
- Saturation: with STALL_CNT_W=4, freeze for 20 cycles → stall_cnt stops at 15. Then rst_n=0 → stall_cnt=0.
